mult_digit_serial: RTL and testbench



---
 rtl/mult_pkg.sv | 27 ++
 rtl/digit_mul.sv | 24 ++
 rtl/mult_digit_serial.sv | 162 ++++++++++++++++
 tb/tb_mult_digit_serial.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Brief    : Shared types and sizing helpers for the digit-serial multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // A digit index never needs fewer than one bit, even for degenerate K.
  function automatic int index_width(input int width, input int digit);
    int k;
    k = num_digits(width, digit);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/digit_mul.sv
`default_nettype none
// ============================================================================
// Module   : digit_mul
// Brief    : Exact unsigned DIGIT x DIGIT base multiplier; swap point for
//            generated base-multiplier cores.
// Revision : 1.0 - initial release
// ============================================================================
module digit_mul #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0]   a,
  input  logic [DIGIT-1:0]   b,
  output logic [2*DIGIT-1:0] p
);

  logic [2*DIGIT-1:0] w_a_ext;
  logic [2*DIGIT-1:0] w_b_ext;

  assign w_a_ext = {{DIGIT{1'b0}}, a};
  assign w_b_ext = {{DIGIT{1'b0}}, b};
  assign p       = w_a_ext * w_b_ext;

endmodule
`default_nettype wire

// File: rtl/mult_digit_serial.sv
`default_nettype none
// ============================================================================
// Module   : mult_digit_serial
// Brief    : Digit-serial signed/unsigned multiplier with valid/ready handshake;
//            one base-multiplier digit pair per cycle, K*K cycles per product.
// Revision : 1.0 - initial release
// ============================================================================
module mult_digit_serial
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product
);

  localparam int c_num_digits = num_digits(WIDTH, DIGIT);
  localparam int c_idx_w      = index_width(WIDTH, DIGIT);
  localparam int c_prod_w     = 2 * WIDTH;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_num_digits - 1);
  localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

  generate
    if (((WIDTH % DIGIT) != 0) || (WIDTH < 2 * DIGIT)) begin : g_bad_params
      $error("mult_digit_serial: WIDTH must be a multiple of DIGIT and >= 2*DIGIT");
    end
  endgenerate

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0]    r_mag_a;
  logic [WIDTH-1:0]    r_mag_b;
  logic                r_neg;
  logic [c_prod_w-1:0] r_acc;
  logic [c_idx_w-1:0]  r_i;
  logic [c_idx_w-1:0]  r_j;
  logic [c_prod_w-1:0] r_product;

  logic                w_accept;
  logic [WIDTH-1:0]    w_mag_a_in;
  logic [WIDTH-1:0]    w_mag_b_in;
  logic                w_zero_op;
  logic                w_last_pair;

  logic [c_num_digits-1:0][DIGIT-1:0] w_digits_a;
  logic [c_num_digits-1:0][DIGIT-1:0] w_digits_b;
  logic [DIGIT-1:0]    w_digit_a;
  logic [DIGIT-1:0]    w_digit_b;
  logic [2*DIGIT-1:0]  w_pp;
  logic [c_prod_w-1:0] w_pp_ext;
  logic [c_prod_w-1:0] w_pp_shifted;
  logic [c_prod_w-1:0] w_acc_sum;
  logic [c_prod_w-1:0] w_result;

  // Unsigned negation of the most negative value yields 2^(WIDTH-1) exactly.
  assign w_mag_a_in = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
  assign w_mag_b_in = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
  assign w_zero_op  = (w_mag_a_in == '0) || (w_mag_b_in == '0);
  assign w_accept   = in_valid && (r_state == IDLE);

  assign w_digits_a  = r_mag_a;
  assign w_digits_b  = r_mag_b;
  assign w_digit_a   = w_digits_a[r_i];
  assign w_digit_b   = w_digits_b[r_j];
  assign w_last_pair = (r_i == c_last_idx) && (r_j == c_last_idx);

  digit_mul #(
    .DIGIT (DIGIT)
  ) u_digit_mul (
    .a (w_digit_a),
    .b (w_digit_b),
    .p (w_pp)
  );

  assign w_pp_ext     = {{(c_prod_w - 2*DIGIT){1'b0}}, w_pp};
  assign w_pp_shifted = w_pp_ext << (DIGIT * (int'(r_i) + int'(r_j)));
  assign w_acc_sum    = r_acc + w_pp_shifted;
  assign w_result     = r_neg ? -w_acc_sum : w_acc_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (w_accept) begin
          w_state_next = w_zero_op ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (w_last_pair) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag_a   <= '0;
      r_mag_b   <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mag_a <= w_mag_a_in;
      r_mag_b <= w_mag_b_in;
      r_neg   <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
      r_acc   <= '0;
      r_i     <= '0;
      r_j     <= '0;
      if (w_zero_op) begin
        r_product <= '0;
      end
    end else if (r_state == BUSY) begin
      r_acc <= w_acc_sum;
      if (r_j == c_last_idx) begin
        r_j <= '0;
        r_i <= r_i + c_idx_one;
      end else begin
        r_j <= r_j + c_idx_one;
      end
      if (w_last_pair) begin
        r_product <= w_result;
      end
    end
  end

  assign out_product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_mult_digit_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_digit_serial
// Brief    : Directed bench for mult_digit_serial with a cycle-level reference
//            model and literal expectations for the headline products.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_digit_serial;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int K     = WIDTH / DIGIT;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;

  int checks = 0;
  int errors = 0;

  // Written by the stimulus, read by the checker.
  logic        lit_en      = 1'b0;
  logic [15:0] lit_val     = '0;
  int          timeout_req = 0;

  mult_digit_serial #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_signed   (in_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic s);
    int pa;
    int pb;
    int p;
    if (s) begin
      pa = int'($signed(a));
      pb = int'($signed(b));
    end else begin
      pa = int'(a);
      pb = int'(b);
    end
    p = pa * pb;
    return p[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: expected outputs for the cycle after the coming edge.
  initial begin : compare
    logic        m_known;
    logic        m_ready;
    logic        m_valid;
    logic        m_valid_q;
    logic        m_lit_en;
    logic [15:0] m_lit;
    logic [15:0] m_prod;
    logic [15:0] m_pending;
    int          m_count;
    m_known = 1'b0; m_ready = 1'b1; m_valid = 1'b0; m_valid_q = 1'b0;
    m_lit_en = 1'b0; m_lit = '0; m_prod = '0; m_pending = '0; m_count = 0;
    forever begin
      @(negedge clk);
      if (m_known) begin
        check("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("out_product", {16'd0, out_product}, {16'd0, m_prod});
        if (m_valid && !m_valid_q && m_lit_en) begin
          check("lit_product", {16'd0, out_product}, {16'd0, m_lit});
          check("lit_model", {16'd0, m_prod}, {16'd0, m_lit});
        end
      end
      if (timeout_req == 1) check("wait_out_valid", {31'd0, out_valid}, 32'd1);
      if (timeout_req == 2) check("wait_in_ready", {31'd0, in_ready}, 32'd1);
      m_valid_q = m_valid;
      if (rst) begin
        m_known = 1'b1; m_ready = 1'b1; m_valid = 1'b0; m_prod = '0; m_count = 0;
      end else if (m_known) begin
        if (m_ready && in_valid) begin
          m_ready  = 1'b0;
          m_lit_en = lit_en;
          m_lit    = lit_val;
          if (in_a == '0 || in_b == '0) begin
            m_valid = 1'b1;
            m_prod  = '0;
          end else begin
            m_count   = K * K;
            m_pending = ref_mul(in_a, in_b, in_signed);
          end
        end else if (m_count > 0) begin
          m_count--;
          if (m_count == 0) begin
            m_valid = 1'b1;
            m_prod  = m_pending;
          end
        end else if (m_valid && out_ready) begin
          m_valid = 1'b0;
          m_ready = 1'b1;
        end
      end
    end
  end

  task automatic raise_timeout(input int code);
    timeout_req = code;
    @(posedge clk); #1;
    timeout_req = 0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) raise_timeout(2);
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic s,
                    input logic [15:0] lit, input logic use_lit, input int stall);
    int n;
    wait_ready();
    in_a = a; in_b = b; in_signed = s;
    lit_val = lit; lit_en = use_lit;
    in_valid = 1'b1;
    if (stall > 0) out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lit_en = 1'b0;
    // Operands are don't-care once accepted.
    in_a = 8'($urandom); in_b = 8'($urandom); in_signed = 1'($urandom);
    n = 0;
    while (!out_valid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) raise_timeout(1);
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 out_ready = 1'b1;
    end
  endtask

  logic [7:0] sweep_vals [8] = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFF, 8'h55};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    op(8'd13,  8'd11,  1'b0, 16'h008F, 1'b1, 0);
    op(8'd255, 8'd255, 1'b0, 16'hFE01, 1'b1, 0);
    op(8'hF9,  8'd5,   1'b1, 16'hFFDD, 1'b1, 0);
    op(8'h80,  8'h80,  1'b1, 16'h4000, 1'b1, 0);
    op(8'h80,  8'h01,  1'b1, 16'hFF80, 1'b1, 0);
    op(8'd0,   8'd200, 1'b0, 16'h0000, 1'b1, 0);
    op(8'hFF,  8'h00,  1'b1, 16'h0000, 1'b1, 0);
    op(8'd9,   8'd9,   1'b0, 16'h0051, 1'b1, 5);
    op(8'hFF,  8'hFF,  1'b1, 16'h0001, 1'b1, 0);
    op(8'h7F,  8'h80,  1'b1, 16'hC080, 1'b1, 0);
    op(8'h80,  8'h80,  1'b0, 16'h4000, 1'b1, 0);

    // Abort an operation part-way through with a synchronous reset.
    wait_ready();
    in_a = 8'd100; in_b = 8'd3; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    op(8'd6, 8'd7, 1'b0, 16'd42, 1'b1, 0);

    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 8; x++) begin
        for (int y = 0; y < 8; y++) begin
          op(sweep_vals[x], sweep_vals[y], 1'(m), 16'h0000, 1'b0, 0);
        end
      end
    end

    // Hold in_valid high: back-to-back operations at the minimum interval.
    wait_ready();
    in_a = 8'hC3; in_b = 8'h5A; in_signed = 1'b1; in_valid = 1'b1;
    repeat (60) @(posedge clk);
    #1 in_b = 8'h00;
    repeat (12) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
